// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: walks 8-half-word fetch blocks, follows BTB/predictor hits,
// splits block-crossing 32-bit branches over two packets, and honours redirects.
module fetch_pc_gen #(
  parameter logic [30:0] RESET_PC = 31'h10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IN_redirValid,
  input  logic [30:0] IN_redirPc,
  output logic        OUT_pcValid,
  output logic [30:0] OUT_pc,
  input  logic        IN_BTB_branchFound,
  input  logic [30:0] IN_BTB_branchDst,
  input  logic [30:0] IN_BTB_branchSrc,
  input  logic        IN_BTB_branchIsJump,
  input  logic        IN_BTB_branchCompr,
  input  logic        IN_BPT_branchTaken,
  input  logic        IN_fetchReady,
  output logic        OUT_fetchValid,
  output logic [30:0] OUT_fetchPc,
  output logic [2:0]  OUT_fetchLastIdx,
  output logic        OUT_predTaken,
  output logic [30:0] OUT_predTarget
);

  typedef enum logic {RUN, CROSS} state_t;

  state_t      r_state, w_nState;
  logic [30:0] r_pc, w_nPc;
  logic [30:0] r_saved, w_nSaved;
  logic        r_fv, w_nFv;
  logic [30:0] r_fpc, w_nFpc;
  logic [2:0]  r_last, w_nLast;
  logic        r_pt, w_nPt;
  logic [30:0] r_tgt, w_nTgt;

  logic        w_advance;
  logic        w_taken;
  logic        w_cross;
  logic [2:0]  w_end;
  logic [30:0] w_seqPc;
  logic        w_unused;

  // Only the slot index of the branch source matters; the BTB already matched the block.
  assign w_unused = ^IN_BTB_branchSrc[30:3];

  assign w_advance   = !IN_redirValid && (!r_fv || IN_fetchReady);
  assign w_taken     = (r_state == RUN) && IN_BTB_branchFound &&
                       (IN_BPT_branchTaken || IN_BTB_branchIsJump);
  assign w_cross     = w_taken && (IN_BTB_branchSrc[2:0] == 3'd7) && !IN_BTB_branchCompr;
  assign w_end       = IN_BTB_branchSrc[2:0] + {2'b00, !IN_BTB_branchCompr};
  assign w_seqPc     = {r_pc[30:3] + 28'd1, 3'b000};

  assign OUT_pc           = r_pc;
  assign OUT_pcValid      = w_advance;
  assign OUT_fetchValid   = r_fv;
  assign OUT_fetchPc      = r_fpc;
  assign OUT_fetchLastIdx = r_last;
  assign OUT_predTaken    = r_pt;
  assign OUT_predTarget   = r_tgt;

  always_comb begin
    w_nState = r_state;
    w_nPc    = r_pc;
    w_nSaved = r_saved;
    w_nFv    = r_fv;
    w_nFpc   = r_fpc;
    w_nLast  = r_last;
    w_nPt    = r_pt;
    w_nTgt   = r_tgt;
    if (IN_redirValid) begin
      w_nPc    = IN_redirPc;
      w_nState = RUN;
      w_nFv    = 1'b0;
    end else if (w_advance) begin
      w_nFv  = 1'b1;
      w_nFpc = r_pc;
      if (r_state == CROSS) begin
        // Second half of a block-crossing branch: its prediction rides on slot 0.
        w_nLast  = 3'd0;
        w_nPt    = 1'b1;
        w_nTgt   = r_saved;
        w_nPc    = r_saved;
        w_nState = RUN;
      end else if (w_cross) begin
        w_nLast  = 3'd7;
        w_nPt    = 1'b0;
        w_nSaved = IN_BTB_branchDst;
        w_nPc    = w_seqPc;
        w_nState = CROSS;
      end else if (w_taken) begin
        w_nLast = w_end;
        w_nPt   = 1'b1;
        w_nTgt  = IN_BTB_branchDst;
        w_nPc   = IN_BTB_branchDst;
      end else begin
        w_nLast = 3'd7;
        w_nPt   = 1'b0;
        w_nPc   = w_seqPc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_saved <= '0;
      r_fv    <= 1'b0;
      r_fpc   <= '0;
      r_last  <= '0;
      r_pt    <= 1'b0;
      r_tgt   <= '0;
    end else begin
      r_state <= w_nState;
      r_pc    <= w_nPc;
      r_saved <= w_nSaved;
      r_fv    <= w_nFv;
      r_fpc   <= w_nFpc;
      r_last  <= w_nLast;
      r_pt    <= w_nPt;
      r_tgt   <= w_nTgt;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed table-driven bench for fetch_pc_gen: each row drives inputs, checks the
// combinational lookup before the edge and the registered packet after it.
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        IN_redirValid;
  logic [30:0] IN_redirPc;
  logic        OUT_pcValid;
  logic [30:0] OUT_pc;
  logic        IN_BTB_branchFound;
  logic [30:0] IN_BTB_branchDst;
  logic [30:0] IN_BTB_branchSrc;
  logic        IN_BTB_branchIsJump;
  logic        IN_BTB_branchCompr;
  logic        IN_BPT_branchTaken;
  logic        IN_fetchReady;
  logic        OUT_fetchValid;
  logic [30:0] OUT_fetchPc;
  logic [2:0]  OUT_fetchLastIdx;
  logic        OUT_predTaken;
  logic [30:0] OUT_predTarget;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_pc_gen dut (
    .clk                (clk),
    .rst                (rst),
    .IN_redirValid      (IN_redirValid),
    .IN_redirPc         (IN_redirPc),
    .OUT_pcValid        (OUT_pcValid),
    .OUT_pc             (OUT_pc),
    .IN_BTB_branchFound (IN_BTB_branchFound),
    .IN_BTB_branchDst   (IN_BTB_branchDst),
    .IN_BTB_branchSrc   (IN_BTB_branchSrc),
    .IN_BTB_branchIsJump(IN_BTB_branchIsJump),
    .IN_BTB_branchCompr (IN_BTB_branchCompr),
    .IN_BPT_branchTaken (IN_BPT_branchTaken),
    .IN_fetchReady      (IN_fetchReady),
    .OUT_fetchValid     (OUT_fetchValid),
    .OUT_fetchPc        (OUT_fetchPc),
    .OUT_fetchLastIdx   (OUT_fetchLastIdx),
    .OUT_predTaken      (OUT_predTaken),
    .OUT_predTarget     (OUT_predTarget)
  );

  // pm: 0 = check packet valid only, 1 = also pc/lastIdx/predTaken, 2 = also target
  typedef struct {
    int rst, rv, rpc, rdy, fnd, src, dst, jmp, cmp, tkn;
    int cc, epv, epc;
    int pm, efv, efpc, elast, ept, etgt;
  } vec_t;

  function automatic vec_t V(input int rst_, rv, rpc, rdy, fnd, src, dst, jmp, cmp, tkn,
                             cc, epv, epc, pm, efv, efpc, elast, ept, etgt);
    vec_t v;
    v.rst = rst_; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.fnd = fnd; v.src = src;
    v.dst = dst; v.jmp = jmp; v.cmp = cmp; v.tkn = tkn; v.cc = cc; v.epv = epv;
    v.epc = epc; v.pm = pm; v.efv = efv; v.efpc = efpc; v.elast = elast;
    v.ept = ept; v.etgt = etgt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    rst                 = v.rst[0];
    IN_redirValid       = v.rv[0];
    IN_redirPc          = v.rpc[30:0];
    IN_fetchReady       = v.rdy[0];
    IN_BTB_branchFound  = v.fnd[0];
    IN_BTB_branchSrc    = v.src[30:0];
    IN_BTB_branchDst    = v.dst[30:0];
    IN_BTB_branchIsJump = v.jmp[0];
    IN_BTB_branchCompr  = v.cmp[0];
    IN_BPT_branchTaken  = v.tkn[0];
    #1;
    if (v.cc != 0) begin
      chk({tag, " pcValid"}, {31'b0, OUT_pcValid}, v.epv);
      chk({tag, " pc"}, {1'b0, OUT_pc}, v.epc);
    end
    @(posedge clk);
    #1;
    chk({tag, " fetchValid"}, {31'b0, OUT_fetchValid}, v.efv);
    if (v.pm >= 1) begin
      chk({tag, " fetchPc"}, {1'b0, OUT_fetchPc}, v.efpc);
      chk({tag, " lastIdx"}, {29'b0, OUT_fetchLastIdx}, v.elast);
      chk({tag, " predTaken"}, {31'b0, OUT_predTaken}, v.ept);
    end
    if (v.pm >= 2)
      chk({tag, " predTarget"}, {1'b0, OUT_predTarget}, v.etgt);
  endtask

  vec_t tbl[26];

  initial begin
    rst = 1'b1; IN_redirValid = 1'b0; IN_redirPc = '0; IN_fetchReady = 1'b1;
    IN_BTB_branchFound = 1'b0; IN_BTB_branchSrc = '0; IN_BTB_branchDst = '0;
    IN_BTB_branchIsJump = 1'b0; IN_BTB_branchCompr = 1'b0; IN_BPT_branchTaken = 1'b0;

    //           rst rv rpc           rdy fnd src          dst          jmp cmp tkn  cc epv epc           pm efv efpc         last pt tgt
    tbl[0]  = V(1, 0, 0,            1,  0, 0,           0,           0, 0, 0,   0, 0, 0,            2, 0, 0,            0, 0, 0);
    tbl[1]  = V(0, 0, 0,            1,  0, 0,           0,           0, 0, 0,   1, 1, 'h10000000,   1, 1, 'h10000000,   7, 0, 0);
    tbl[2]  = V(0, 0, 0,            1,  0, 0,           0,           0, 0, 0,   1, 1, 'h10000008,   1, 1, 'h10000008,   7, 0, 0);
    tbl[3]  = V(0, 0, 0,            1,  0, 0,           0,           0, 0, 0,   1, 1, 'h10000010,   1, 1, 'h10000010,   7, 0, 0);
    tbl[4]  = V(0, 1, 'h10000000,   1,  0, 0,           0,           0, 0, 0,   1, 0, 'h10000018,   0, 0, 0,            0, 0, 0);
    tbl[5]  = V(0, 0, 0,            1,  1, 'h10000003,  'h10000100,  0, 1, 1,   1, 1, 'h10000000,   2, 1, 'h10000000,   3, 1, 'h10000100);
    tbl[6]  = V(0, 0, 0,            1,  0, 0,           0,           0, 0, 0,   1, 1, 'h10000100,   1, 1, 'h10000100,   7, 0, 0);
    tbl[7]  = V(0, 1, 'h10000000,   1,  0, 0,           0,           0, 0, 0,   1, 0, 'h10000108,   0, 0, 0,            0, 0, 0);
    tbl[8]  = V(0, 0, 0,            1,  1, 'h10000007,  'h200,       1, 0, 0,   1, 1, 'h10000000,   1, 1, 'h10000000,   7, 0, 0);
    tbl[9]  = V(0, 0, 0,            1,  1, 'h1000000A,  'h5554,      0, 1, 1,   1, 1, 'h10000008,   2, 1, 'h10000008,   0, 1, 'h200);
    tbl[10] = V(0, 0, 0,            1,  0, 0,           0,           0, 0, 0,   1, 1, 'h200,        1, 1, 'h200,        7, 0, 0);
    tbl[11] = V(0, 0, 0,            0,  1, 'h20A,       'h998,       1, 1, 1,   1, 0, 'h208,        1, 1, 'h200,        7, 0, 0);
    tbl[12] = V(0, 0, 0,            0,  1, 'h20A,       'h998,       1, 1, 1,   1, 0, 'h208,        1, 1, 'h200,        7, 0, 0);
    tbl[13] = V(0, 0, 0,            0,  1, 'h20A,       'h998,       1, 1, 1,   1, 0, 'h208,        1, 1, 'h200,        7, 0, 0);
    tbl[14] = V(0, 0, 0,            1,  0, 0,           0,           0, 0, 0,   1, 1, 'h208,        1, 1, 'h208,        7, 0, 0);
    tbl[15] = V(0, 0, 0,            1,  1, 'h217,       'h4000,      0, 0, 1,   1, 1, 'h210,        1, 1, 'h210,        7, 0, 0);
    tbl[16] = V(0, 0, 0,            0,  0, 0,           0,           0, 0, 0,   1, 0, 'h218,        1, 1, 'h210,        7, 0, 0);
    tbl[17] = V(0, 1, 'h3005,       0,  0, 0,           0,           0, 0, 0,   1, 0, 'h218,        0, 0, 0,            0, 0, 0);
    tbl[18] = V(0, 0, 0,            1,  0, 0,           0,           0, 0, 0,   1, 1, 'h3005,       1, 1, 'h3005,       7, 0, 0);
    tbl[19] = V(0, 1, 'h7FFFFFF8,   1,  0, 0,           0,           0, 0, 0,   1, 0, 'h3008,       0, 0, 0,            0, 0, 0);
    tbl[20] = V(0, 0, 0,            1,  0, 0,           0,           0, 0, 0,   1, 1, 'h7FFFFFF8,   1, 1, 'h7FFFFFF8,   7, 0, 0);
    tbl[21] = V(0, 0, 0,            1,  0, 0,           0,           0, 0, 0,   1, 1, 0,            1, 1, 0,            7, 0, 0);
    tbl[22] = V(1, 1, 'h1234,       1,  0, 0,           0,           0, 0, 0,   1, 0, 'h8,          2, 0, 0,            0, 0, 0);
    tbl[23] = V(0, 0, 0,            1,  0, 0,           0,           0, 0, 0,   1, 1, 'h10000000,   1, 1, 'h10000000,   7, 0, 0);
    tbl[24] = V(0, 0, 0,            1,  1, 'h1000000F,  'h40,        0, 1, 1,   1, 1, 'h10000008,   2, 1, 'h10000008,   7, 1, 'h40);
    tbl[25] = V(0, 0, 0,            1,  1, 'h45,        'h998,       0, 0, 0,   1, 1, 'h40,         1, 1, 'h40,         7, 0, 0);

    for (int i = 0; i < 26; i++)
      apply(tbl[i], $sformatf("row%0d", i));

    // Reset arriving mid CROSS (with a redirect asserted) must restart cleanly in RUN.
    apply(V(0, 0, 0, 1, 1, 'h4F, 'h777, 1, 0, 0,  1, 1, 'h48,  1, 1, 'h48, 7, 0, 0), "crossA");
    apply(V(1, 1, 'h999, 1, 0, 0, 0, 0, 0, 0,     1, 0, 'h50,  2, 0, 0, 0, 0, 0), "crossRst");
    apply(V(0, 0, 0, 1, 0, 0, 0, 0, 0, 0,         1, 1, 'h10000000, 1, 1, 'h10000000, 7, 0, 0), "crossAfter");
    apply(V(0, 0, 0, 1, 0, 0, 0, 0, 0, 0,         1, 1, 'h10000008, 1, 1, 'h10000008, 7, 0, 0), "crossAfter2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 SHALL have parameter RESET_PC, default 31'h10000000, the half-word fetch address loaded on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port IN_redirValid, input, 1, redirect request from branch resolution or trap.
REQ-005 SHALL have port IN_redirPc, input, 31, half-word redirect target.
REQ-006 SHALL have port OUT_pcValid, output, 1, lookup valid to the branch target buffer and predictor.
REQ-007 SHALL have port OUT_pc, output, 31, half-word lookup address; bits [2:0] give the slot within an 8-half-word fetch block.
REQ-008 SHALL have ports IN_BTB_branchFound (1), IN_BTB_branchDst (31), IN_BTB_branchSrc (31), IN_BTB_branchIsJump (1), IN_BTB_branchCompr (1), all inputs, combinational BTB answer for OUT_pc in the same cycle.
REQ-009 SHALL have port IN_BPT_branchTaken, input, 1, direction prediction for the found branch.
REQ-010 SHALL have port IN_fetchReady, input, 1, downstream accepts the fetch packet.
REQ-011 SHALL have outputs OUT_fetchValid (1), OUT_fetchPc (31), OUT_fetchLastIdx (3), OUT_predTaken (1), OUT_predTarget (31), a registered fetch packet.

Function
REQ-012 SHALL hold a pc register, a state register {RUN, CROSS}, a saved-target register (31b) and the packet register.
REQ-013 SHALL drive OUT_pc = pc register, combinationally.
REQ-014 SHALL define advance = !IN_redirValid && (!OUT_fetchValid || IN_fetchReady); OUT_pcValid SHALL equal advance.
REQ-015 SHALL define predicted-taken (RUN only) = IN_BTB_branchFound && (IN_BPT_branchTaken || IN_BTB_branchIsJump).
REQ-016 RUN, advance, not taken: packet <= {valid 1, pc, lastIdx 7, predTaken 0, target x}; pc <= {pc[30:3]+1, 3'b000}; stay RUN.
REQ-017 RUN, advance, taken, end = IN_BTB_branchSrc[2:0] + !IN_BTB_branchCompr <= 7: packet <= {1, pc, end, 1, IN_BTB_branchDst}; pc <= IN_BTB_branchDst; stay RUN.
REQ-018 RUN, advance, taken, branchSrc[2:0] == 7 and branchCompr == 0 (instruction crosses block): packet <= {1, pc, 7, 0, x}; saved target <= IN_BTB_branchDst; pc <= {pc[30:3]+1, 3'b000}; state <= CROSS.
REQ-019 CROSS, advance: BTB/predictor inputs ignored; packet <= {1, pc, 0, 1, saved target}; pc <= saved target; state <= RUN.
REQ-020 No advance, no redirect: pc, state, saved target, packet all hold.
REQ-021 Downstream handshake: packet transfers when OUT_fetchValid && IN_fetchReady; if not refilled that cycle, OUT_fetchValid <= 0.
REQ-022 IN_redirValid has priority over everything: pc <= IN_redirPc, state <= RUN, OUT_fetchValid <= 0 (flush), regardless of IN_fetchReady or current state.
REQ-023 Sequential increment SHALL wrap modulo 2^28 in pc[30:3]; pc 31'h7FFFFFF8 advances to 31'h0.
REQ-024 Redirect to a mid-block address (pc[2:0] != 0) SHALL fetch from that slot; OUT_fetchPc carries the unaligned pc.

Reset
REQ-025 On rst: pc <= RESET_PC, state <= RUN, OUT_fetchValid <= 0, OUT_predTaken <= 0, OUT_fetchLastIdx <= 0, OUT_fetchPc <= 0, OUT_predTarget <= 0, saved target <= 0.
REQ-026 rst SHALL override IN_redirValid and any in-progress CROSS sequence in the same cycle.
REQ-027 First cycle after reset deassertion with IN_fetchReady=1, no redirect: OUT_pcValid=1, OUT_pc=RESET_PC.

Verification
REQ-028 Reset, no BTB hits, ready=1 -> OUT_pc 0x10000000, 0x10000008, 0x10000010 on successive cycles; packets lastIdx 7, predTaken 0.
REQ-029 OUT_pc=0x10000000, BTB found src 0x10000003 compr=1 dst 0x10000100 taken=1 -> packet lastIdx 3, predTaken 1, target 0x10000100; next OUT_pc 0x10000100.
REQ-030 BTB found src 0x10000007 compr=0 isJump=1 dst 0x200 -> packet lastIdx 7 predTaken 0; next packet pc 0x10000008 lastIdx 0 predTaken 1 target 0x200; then OUT_pc 0x200.
REQ-031 OUT_fetchValid=1, IN_fetchReady=0 for 3 cycles -> OUT_pcValid=0, packet and OUT_pc stable; ready=1 -> advance resumes.
REQ-032 IN_redirValid=1, IN_redirPc 0x3005 during CROSS with stalled packet -> next cycle OUT_fetchValid=0, state RUN, OUT_pc 0x3005; following packet fetchPc 0x3005.
REQ-033 Redirect to 0x7FFFFFF8, no hits -> next OUT_pc 0x00000000.
